// File: rtl/dest_hazard_unit.sv
// Destination tracking through EX/MEM/WB for a 5-stage MIPS-style core:
// operand forwarding selects, load-use stall, decode bypass flags and the register-file write port.
module dest_hazard_unit #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] dest_address,
  input  logic          dest_we,
  input  logic          dest_is_load,
  input  logic          id_valid,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic          rs_used,
  input  logic          rt_used,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          id_byp_rs,
  output logic          id_byp_rt,
  output logic [AW-1:0] ex_dest,
  output logic [AW-1:0] mem_dest,
  output logic [AW-1:0] wb_dest,
  output logic          wb_we
);

  logic          ex_valid;
  logic          ex_is_load;
  logic [AW-1:0] ex_rs;
  logic [AW-1:0] ex_rt;
  logic          ex_rs_used;
  logic          ex_rt_used;
  logic          mem_valid;
  logic          mem_is_load;
  logic          wb_valid;

  logic          issue;
  logic          issue_valid;
  logic          stall_rs;
  logic          stall_rt;

  // Flush takes precedence over everything: a flushed or stalled slot becomes a bubble.
  assign issue       = id_valid & ~stall & ~flush;
  assign issue_valid = issue & dest_we & (dest_address != '0);

  // Register 0 is never a real destination, so a zero source can never match a valid entry.
  assign stall_rs = rs_used & (rs_addr != '0) & (rs_addr == ex_dest);
  assign stall_rt = rt_used & (rt_addr != '0) & (rt_addr == ex_dest);
  assign stall    = id_valid & ex_valid & ex_is_load & (stall_rs | stall_rt);

  always_comb begin
    fwd_a = 2'b00;
    if (ex_rs_used && (ex_rs != '0)) begin
      if (mem_valid && !mem_is_load && (ex_rs == mem_dest))
        fwd_a = 2'b01;
      else if (wb_valid && (ex_rs == wb_dest))
        fwd_a = 2'b10;
    end
  end

  always_comb begin
    fwd_b = 2'b00;
    if (ex_rt_used && (ex_rt != '0)) begin
      if (mem_valid && !mem_is_load && (ex_rt == mem_dest))
        fwd_b = 2'b01;
      else if (wb_valid && (ex_rt == wb_dest))
        fwd_b = 2'b10;
    end
  end

  assign id_byp_rs = id_valid & rs_used & wb_valid & (rs_addr != '0) & (rs_addr == wb_dest);
  assign id_byp_rt = id_valid & rt_used & wb_valid & (rt_addr != '0) & (rt_addr == wb_dest);
  assign wb_we     = wb_valid;

  // Stages below decode never stall; every edge shifts the whole pipe by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_dest     <= '0;
      ex_is_load  <= 1'b0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rs_used  <= 1'b0;
      ex_rt_used  <= 1'b0;
      mem_valid   <= 1'b0;
      mem_dest    <= '0;
      mem_is_load <= 1'b0;
      wb_valid    <= 1'b0;
      wb_dest     <= '0;
    end else begin
      ex_valid   <= issue_valid;
      ex_dest    <= issue_valid ? dest_address : '0;
      ex_is_load <= issue_valid & dest_is_load;
      if (issue) begin
        ex_rs      <= rs_addr;
        ex_rt      <= rt_addr;
        ex_rs_used <= rs_used;
        ex_rt_used <= rt_used;
      end else begin
        ex_rs      <= '0;
        ex_rt      <= '0;
        ex_rs_used <= 1'b0;
        ex_rt_used <= 1'b0;
      end
      mem_valid   <= ex_valid;
      mem_dest    <= ex_dest;
      mem_is_load <= ex_is_load;
      wb_valid    <= mem_valid;
      wb_dest     <= mem_dest;
    end
  end

endmodule

// File: tb/tb_dest_hazard_unit.sv
// Directed bench for dest_hazard_unit: forwarding, load-use stall, bypass, register 0, flush and reset.
module tb_dest_hazard_unit;

  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] dest_address;
  logic          dest_we;
  logic          dest_is_load;
  logic          id_valid;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic          rs_used;
  logic          rt_used;
  logic          flush;
  logic          stall;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          id_byp_rs;
  logic          id_byp_rt;
  logic [AW-1:0] ex_dest;
  logic [AW-1:0] mem_dest;
  logic [AW-1:0] wb_dest;
  logic          wb_we;

  int compared   = 0;
  int mismatched = 0;

  dest_hazard_unit #(.AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .dest_address (dest_address),
    .dest_we      (dest_we),
    .dest_is_load (dest_is_load),
    .id_valid     (id_valid),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_used      (rs_used),
    .rt_used      (rt_used),
    .flush        (flush),
    .stall        (stall),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .id_byp_rs    (id_byp_rs),
    .id_byp_rt    (id_byp_rt),
    .ex_dest      (ex_dest),
    .mem_dest     (mem_dest),
    .wb_dest      (wb_dest),
    .wb_we        (wb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int v, input int d, input int we, input int ld,
                               input int rs, input int rsu, input int rt, input int rtu,
                               input int fl);
    id_valid     = (v != 0);
    dest_address = AW'(d);
    dest_we      = (we != 0);
    dest_is_load = (ld != 0);
    rs_addr      = AW'(rs);
    rs_used      = (rsu != 0);
    rt_addr      = AW'(rt);
    rt_used      = (rtu != 0);
    flush        = (fl != 0);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " stall"},     32'(stall),     0);
    checkOutput({tag, " fwd_a"},     32'(fwd_a),     0);
    checkOutput({tag, " fwd_b"},     32'(fwd_b),     0);
    checkOutput({tag, " id_byp_rs"}, 32'(id_byp_rs), 0);
    checkOutput({tag, " id_byp_rt"}, 32'(id_byp_rt), 0);
    checkOutput({tag, " ex_dest"},   32'(ex_dest),   0);
    checkOutput({tag, " mem_dest"},  32'(mem_dest),  0);
    checkOutput({tag, " wb_dest"},   32'(wb_dest),   0);
    checkOutput({tag, " wb_we"},     32'(wb_we),     0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    rst = 1'b1;
    idle();
    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;
    step();

    // ALU chain: add r5, then sub using r5, then a consumer of r5 two behind
    applyStimulus(1, 5, 1, 0, 1, 1, 2, 1, 0);
    settle();
    checkOutput("alu stall", 32'(stall), 0);
    step();
    applyStimulus(1, 6, 1, 0, 5, 1, 7, 1, 0);
    settle();
    checkOutput("alu ex_dest", 32'(ex_dest), 5);
    checkOutput("alu fwd_a none", 32'(fwd_a), 0);
    step();
    applyStimulus(1, 7, 1, 0, 9, 1, 5, 1, 0);
    settle();
    checkOutput("alu fwd_a exmem", 32'(fwd_a), 1);
    checkOutput("alu fwd_b idle", 32'(fwd_b), 0);
    checkOutput("alu mem_dest", 32'(mem_dest), 5);
    step();
    applyStimulus(1, 0, 0, 0, 5, 1, 5, 0, 0);
    settle();
    checkOutput("alu fwd_b memwb", 32'(fwd_b), 2);
    checkOutput("alu fwd_a rs9", 32'(fwd_a), 0);
    checkOutput("alu wb_we", 32'(wb_we), 1);
    checkOutput("alu wb_dest", 32'(wb_dest), 5);
    checkOutput("alu id_byp_rs", 32'(id_byp_rs), 1);
    checkOutput("alu id_byp_rt unused", 32'(id_byp_rt), 0);
    step();
    idle();
    settle();
    checkOutput("alu wb_dest sub", 32'(wb_dest), 6);
    checkOutput("alu wb_we sub", 32'(wb_we), 1);
    step();
    settle();
    checkOutput("alu wb_dest third", 32'(wb_dest), 7);
    step();
    settle();
    checkOutput("alu wb_we drained", 32'(wb_we), 0);
    checkOutput("alu wb_dest bubble", 32'(wb_dest), 0);
    step();

    // Load-use: exactly one stall cycle, then forward from MEM/WB
    applyStimulus(1, 8, 1, 1, 1, 1, 2, 0, 0);
    settle();
    checkOutput("lu stall load", 32'(stall), 0);
    step();
    applyStimulus(1, 10, 1, 0, 8, 1, 3, 1, 0);
    settle();
    checkOutput("lu stall", 32'(stall), 1);
    step();
    settle();
    checkOutput("lu stall released", 32'(stall), 0);
    checkOutput("lu ex bubble", 32'(ex_dest), 0);
    checkOutput("lu mem_dest", 32'(mem_dest), 8);
    step();
    idle();
    settle();
    checkOutput("lu fwd_a memwb", 32'(fwd_a), 2);
    checkOutput("lu ex_dest dep", 32'(ex_dest), 10);
    checkOutput("lu wb_dest", 32'(wb_dest), 8);
    checkOutput("lu wb_we", 32'(wb_we), 1);
    step();
    idleCycles(3);

    // Double hazard: MEM and WB both hold r3, MEM wins
    applyStimulus(1, 3, 1, 0, 1, 0, 2, 0, 0);
    step();
    applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 4, 1, 0, 3, 1, 0, 1, 0);
    settle();
    checkOutput("dbl stall", 32'(stall), 0);
    step();
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 0);
    settle();
    checkOutput("dbl fwd_a", 32'(fwd_a), 1);
    checkOutput("dbl fwd_b src0", 32'(fwd_b), 0);
    checkOutput("dbl src0 stall", 32'(stall), 0);
    checkOutput("dbl src0 byp", 32'(id_byp_rs), 0);
    step();
    idleCycles(3);

    // Register 0 destination never becomes a valid entry
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput($sformatf("r0 wb_we %0d", i), 32'(wb_we), 0);
      step();
    end

    // Flush turns the decode instruction into a bubble
    applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 1);
    step();
    idle();
    settle();
    checkOutput("flush ex_dest", 32'(ex_dest), 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput($sformatf("flush wb_we %0d", i), 32'(wb_we), 0);
      step();
    end

    // Flush together with a load-use stall
    applyStimulus(1, 12, 1, 1, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 13, 1, 0, 12, 1, 0, 0, 1);
    settle();
    checkOutput("fs stall", 32'(stall), 1);
    step();
    idle();
    settle();
    checkOutput("fs ex bubble", 32'(ex_dest), 0);
    checkOutput("fs mem_dest", 32'(mem_dest), 12);
    step();
    settle();
    checkOutput("fs wb_dest", 32'(wb_dest), 12);
    checkOutput("fs wb_we", 32'(wb_we), 1);
    step();
    settle();
    checkOutput("fs no write 13", 32'(wb_we), 0);
    step();
    idleCycles(2);

    // Asynchronous reset with three valid entries in flight
    applyStimulus(1, 20, 1, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 21, 1, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 22, 1, 0, 21, 1, 0, 0, 0);
    step();
    applyStimulus(1, 0, 0, 0, 20, 1, 20, 1, 0);
    settle();
    checkOutput("pre-reset fwd_a", 32'(fwd_a), 1);
    checkOutput("pre-reset byp", 32'(id_byp_rs), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkAllZero("midreset");
    idle();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      checkOutput($sformatf("post-reset wb_we %0d", i), 32'(wb_we), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dest_hazard_unit.md
# dest_hazard_unit

Tracks destination register addresses produced by the decode-stage destination mux through the EX, MEM and WB pipeline stages of the 5-stage MIPS-style core. Each cycle it compares the source registers of in-flight instructions against pending destinations. It generates ALU operand forwarding selects, a load-use stall, and decode-stage register-file bypass flags. It also delivers the final write address and write enable to the register file.

## Interface
Parameters:
- AW, 5, register address width (32 registers; register 0 is hardwired zero)

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- dest_address  in  AW  destination from the decode destination mux (rt or rd already selected)
- dest_we  in  1  decode instruction writes a register
- dest_is_load  in  1  decode instruction is a load (result available after MEM)
- id_valid  in  1  decode holds a valid instruction
- rs_addr, rt_addr  in  AW  decode source registers
- rs_used, rt_used  in  1  decode instruction actually reads rs / rt
- flush  in  1  taken branch or jump; decode instruction must not enter EX
- stall  out  1  load-use hazard; upstream holds IF/ID, a bubble enters EX
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 never driven
- id_byp_rs, id_byp_rt  out  1  decode source equals the register being written in WB this cycle
- ex_dest, mem_dest, wb_dest  out  AW  destination held in each stage
- wb_we  out  1  register-file write enable for wb_dest

## Operation
- State per stage: valid, dest (AW), is_load; EX additionally holds rs, rt, rs_used, rt_used.
- Issue entry: valid = id_valid & dest_we & (dest_address != 0) & ~stall & ~flush. Sources are captured when id_valid & ~stall & ~flush; otherwise the EX source-used bits are cleared.
- Shift each cycle: EX <- issue entry, MEM <- EX, WB <- MEM. The pipeline below decode never stalls.
- stall (combinational) = id_valid & EX.valid & EX.is_load & ((rs_used & rs_addr == EX.dest) | (rt_used & rt_addr == EX.dest)). rs or rt equal to 0 never stalls.
- fwd_a (combinational, EX operand rs):
  - 01 if MEM.valid & EX.rs_used & EX.rs == MEM.dest & ~MEM.is_load
  - else 10 if WB.valid & EX.rs_used & EX.rs == WB.dest
  - else 00
  - MEM has priority over WB.
  - MEM.is_load never forwards from EX/MEM; the stall prevents that case.
- fwd_b: same rule using rt.
- A source of 0 always selects 00.
- id_byp_rs = id_valid & rs_used & WB.valid & rs_addr == WB.dest; id_byp_rt analogous.
- wb_we = WB.valid; wb_dest = WB.dest. Stage dest outputs show the stored dest even when the stage is invalid. A bubble stores dest 0.
- flush and stall together: flush wins for issue (bubble), and stall is still reported.

## Timing
- Reset, asynchronous: all valid, is_load and used bits go to 0 and all dest/src fields to 0. stall=0, fwd_a=fwd_b=00, id_byp_*=0, wb_we=0, all *_dest=0. This takes effect immediately and holds until the first rising edge after rst falls.
- Reset mid-operation discards every in-flight entry. No wb_we pulse occurs for discarded instructions.
- Latency: an instruction issued at edge N is in EX after N, MEM after N+1, WB after N+2. wb_we is high for exactly one cycle, cycles N+2 to N+3.
- stall, fwd_*, id_byp_* are purely combinational from current state and inputs. No registered outputs beyond stage state.
- A load followed immediately by a dependent instruction gives exactly one stall cycle. On the next cycle the load is in MEM and the dependent instruction issues. The dependent instruction later gets fwd=10 in EX.

## Test plan
- Reset: assert rst mid-stream with 3 valid entries → all outputs 0 immediately. After release, no wb_we for ~3 cycles without new issue.
- ALU chain: issue add dest=5, then sub rs=5 → second cycle fwd_a=01. An instruction two behind with rt=5 → fwd_b=10. wb_we=1, wb_dest=5 exactly 2 cycles after issue.
- Load-use: load dest=8, next rs_addr=8 rs_used=1 → stall=1 for one cycle. Then issue, and in EX fwd_a=10.
- Double hazard priority: EX/MEM and MEM/WB both dest=3, EX rs=3 → fwd_a=01.
- Register 0: dest_address=0 with dest_we=1 → no valid entry and wb_we stays 0. A source of 0 → fwd 00, no stall.
- Flush: flush=1 with id_valid, dest=9 → EX bubble and wb_we never asserts for 9. Flush coinciding with a load-use stall → stall=1 and a bubble is issued.
